// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : MEM-stage load/store initiator for the 64Kx32 word-addressed data
//            memory. Stores are absorbed in an in-order store buffer and
//            drained when the shared port is granted. Loads forward from the
//            buffer (youngest match) or issue a registered memory read.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
    parameter int SB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    input  logic        dm_gnt_i,
    output logic        dm_r_o,
    output logic        dm_w_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    input  logic [31:0] dm_rdata_i,
    output logic        sb_empty_o
);

    localparam int              C_PTR_W  = $clog2(SB_DEPTH);
    localparam logic [C_PTR_W:0] C_DEPTH = (C_PTR_W + 1)'(SB_DEPTH);

    localparam logic [1:0] C_ST_IDLE     = 2'd0;
    localparam logic [1:0] C_ST_RD_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_RD_DATA  = 2'd2;
    localparam logic [1:0] C_ST_FWD_RSP  = 2'd3;

    logic [1:0]         r_state_q;
    logic [1:0]         w_state_d;

    logic [15:0]        r_sb_addr_q [SB_DEPTH];
    logic [31:0]        r_sb_data_q [SB_DEPTH];
    logic [C_PTR_W-1:0] r_head_q;
    logic [C_PTR_W-1:0] r_tail_q;
    logic [C_PTR_W:0]   r_count_q;

    logic [15:0]        r_ld_addr_q;
    logic [31:0]        r_fwd_data_q;

    logic               w_sb_full;
    logic               w_sb_empty;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_ld_accept;
    logic               w_hit;
    logic [31:0]        w_hit_data;
    logic [15:0]        w_unused_addr_hi;

    // Only the low 16 address bits select a word; the rest is ignored.
    assign w_unused_addr_hi = req_addr_i[31:16];

    // Handshake: fullness is judged on the registered count, so a same-cycle
    // drain pop never frees a slot for the store being offered.
    assign w_sb_full   = (r_count_q == C_DEPTH);
    assign w_sb_empty  = (r_count_q == '0);
    assign req_ready_o = (r_state_q != C_ST_RD_ISSUE) && (!req_we_i || !w_sb_full);
    assign w_accept    = req_valid_i && req_ready_o;
    assign w_push      = w_accept && req_we_i;
    assign w_ld_accept = w_accept && !req_we_i;
    assign w_pop       = dm_w_o;
    assign sb_empty_o  = w_sb_empty;

    // Forwarding search: walk oldest to youngest so the youngest match wins.
    // The head entry still counts even if it drains this same cycle.
    always_comb begin : p_fwd
        logic [C_PTR_W-1:0] idx;
        idx        = '0;
        w_hit      = 1'b0;
        w_hit_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = r_head_q + C_PTR_W'(i);
            if (((C_PTR_W + 1)'(i) < r_count_q) &&
                (r_sb_addr_q[idx] == req_addr_i[15:0])) begin
                w_hit      = 1'b1;
                w_hit_data = r_sb_data_q[idx];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= C_ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM next state: a new load may start from any non-issuing state, which
    // gives back-to-back responses.
    always_comb begin
        w_state_d = C_ST_IDLE;
        case (r_state_q)
            C_ST_RD_ISSUE: w_state_d = dm_gnt_i ? C_ST_RD_DATA : C_ST_RD_ISSUE;
            default: begin
                if (w_ld_accept) begin
                    w_state_d = w_hit ? C_ST_FWD_RSP : C_ST_RD_ISSUE;
                end else begin
                    w_state_d = C_ST_IDLE;
                end
            end
        endcase
    end

    // FSM outputs: the pending read owns the port in RD_ISSUE; otherwise the
    // store buffer head drains whenever granted. Address/data are zero idle.
    always_comb begin
        rsp_valid_o = 1'b0;
        rsp_rdata_o = '0;
        dm_r_o      = 1'b0;
        dm_w_o      = 1'b0;
        dm_addr_o   = '0;
        dm_wdata_o  = '0;
        case (r_state_q)
            C_ST_RD_ISSUE: begin
                dm_r_o = dm_gnt_i;
                if (dm_gnt_i) begin
                    dm_addr_o = {16'b0, r_ld_addr_q};
                end
            end
            C_ST_RD_DATA: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = dm_rdata_i;
            end
            C_ST_FWD_RSP: begin
                rsp_valid_o = 1'b1;
                rsp_rdata_o = r_fwd_data_q;
            end
            default: ;
        endcase
        if ((r_state_q != C_ST_RD_ISSUE) && !w_sb_empty && dm_gnt_i) begin
            dm_w_o     = 1'b1;
            dm_addr_o  = {16'b0, r_sb_addr_q[r_head_q]};
            dm_wdata_o = r_sb_data_q[r_head_q];
        end
    end

    // Load bookkeeping: latch the miss address and the forwarded data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_addr_q  <= '0;
            r_fwd_data_q <= '0;
        end else if (w_ld_accept) begin
            r_ld_addr_q  <= req_addr_i[15:0];
            r_fwd_data_q <= w_hit_data;
        end
    end

    // Store buffer: circular FIFO, push at tail, pop at head, count nets out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb_addr_q[i] <= '0;
                r_sb_data_q[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_sb_addr_q[r_tail_q] <= req_addr_i[15:0];
                r_sb_data_q[r_tail_q] <= req_wdata_i;
                r_tail_q              <= r_tail_q + 1'b1;
            end
            if (w_pop) begin
                r_head_q <= r_head_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count_q <= r_count_q + 1'b1;
                2'b01:   r_count_q <= r_count_q - 1'b1;
                default: r_count_q <= r_count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Directed self-checking bench for dmem_access_unit with a simple
//            registered-read data memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        dm_gnt;
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        sb_empty;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [65536];

    dmem_access_unit #(.SB_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .dm_gnt_i    (dm_gnt),
        .dm_r_o      (dm_r),
        .dm_w_o      (dm_w),
        .dm_addr_o   (dm_addr),
        .dm_wdata_o  (dm_wdata),
        .dm_rdata_i  (dm_rdata),
        .sb_empty_o  (sb_empty)
    );

    always #5 clk = ~clk;

    // Data memory model: registered read, write on strobe.
    always @(posedge clk) begin
        if (dm_r) dm_rdata <= mem[dm_addr[15:0]];
        if (dm_w) mem[dm_addr[15:0]] <= dm_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Port-sharing rules hold at every sample point.
    task automatic chk_strobes(input string tag);
        chk({tag, " r&w"}, 32'(dm_r & dm_w), 32'd0);
        chk({tag, " no-gnt"}, 32'((dm_r | dm_w) & ~dm_gnt), 32'd0);
    endtask

    // Advance to the next sample point: inputs are changed at the negedge by
    // the caller, outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
        mem[2]    = 32'd31;
        mem[16'h20] = 32'h55;
        dm_rdata  = 32'd0;
        rst_n     = 1'b0;
        dm_gnt    = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0);

        // ---------------- reset state ----------------
        step(); #1;
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst dm_r", 32'(dm_r), 32'd0);
        chk("rst dm_w", 32'(dm_w), 32'd0);
        chk("rst dm_addr", dm_addr, 32'd0);
        chk("rst sb_empty", 32'(sb_empty), 32'd1);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        step(); rst_n = 1'b1;

        // ---------------- reset mid-load ----------------
        step(); drive(1'b1, 1'b0, 32'd2, 32'd0); #1;
        chk("midrst ready", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0); #1;
        chk("midrst in RD_ISSUE ready", 32'(req_ready), 32'd0);
        chk("midrst no gnt dm_r", 32'(dm_r), 32'd0);
        rst_n = 1'b0; #1;
        chk("midrst dm_r", 32'(dm_r), 32'd0);
        chk("midrst dm_addr", dm_addr, 32'd0);
        chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst sb_empty", 32'(sb_empty), 32'd1);
        chk("midrst ready", 32'(req_ready), 32'd1);
        dm_gnt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("midrst no rsp", 32'(rsp_valid), 32'd0);
            chk("midrst no dm_r", 32'(dm_r), 32'd0);
        end
        rst_n = 1'b1;

        // ---------------- load miss ----------------
        step(); dm_gnt = 1'b1; drive(1'b1, 1'b0, 32'd2, 32'd0); #1;
        chk("miss ready", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0); #1;
        chk("miss C1 dm_r", 32'(dm_r), 32'd1);
        chk("miss C1 dm_addr", dm_addr, 32'd2);
        chk("miss C1 rsp_valid", 32'(rsp_valid), 32'd0);
        chk_strobes("miss C1");
        step(); #1;
        chk("miss C2 rsp_valid", 32'(rsp_valid), 32'd1);
        chk("miss C2 rsp_rdata", rsp_rdata, 32'd31);
        step(); #1;
        chk("miss C3 rsp_valid", 32'(rsp_valid), 32'd0);

        // ---------------- forward youngest / alias ----------------
        step(); dm_gnt = 1'b0; drive(1'b1, 1'b1, 32'd3, 32'd1); #1;
        chk("fwd st1 ready", 32'(req_ready), 32'd1);
        step(); drive(1'b1, 1'b1, 32'h0001_0003, 32'd2); #1;
        chk("fwd st2 ready", 32'(req_ready), 32'd1);
        step(); drive(1'b1, 1'b0, 32'd3, 32'd0); #1;
        chk("fwd ld ready", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0); #1;
        chk("fwd rsp_valid", 32'(rsp_valid), 32'd1);
        chk("fwd rsp_rdata", rsp_rdata, 32'd2);
        chk("fwd dm_r", 32'(dm_r), 32'd0);
        chk("fwd sb_empty", 32'(sb_empty), 32'd0);
        step(); dm_gnt = 1'b1; #1;
        chk("fwd after rsp_valid", 32'(rsp_valid), 32'd0);
        chk("fwd drain0 dm_w", 32'(dm_w), 32'd1);
        chk("fwd drain0 addr", dm_addr, 32'd3);
        chk("fwd drain0 data", dm_wdata, 32'd1);
        step(); #1;
        chk("fwd drain1 dm_w", 32'(dm_w), 32'd1);
        chk("fwd drain1 addr", dm_addr, 32'd3);
        chk("fwd drain1 data", dm_wdata, 32'd2);
        step(); #1;
        chk("fwd drained dm_w", 32'(dm_w), 32'd0);
        chk("fwd drained addr", dm_addr, 32'd0);
        chk("fwd drained wdata", dm_wdata, 32'd0);
        chk("fwd drained sb_empty", 32'(sb_empty), 32'd1);

        // ---------------- full buffer ----------------
        dm_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); drive(1'b1, 1'b1, 32'h10 + 32'(k), 32'hA0 + 32'(k)); #1;
            chk("full push ready", 32'(req_ready), 32'd1);
        end
        step(); drive(1'b1, 1'b1, 32'h14, 32'hA4); #1;
        chk("full 5th store ready", 32'(req_ready), 32'd0);
        drive(1'b1, 1'b0, 32'h20, 32'd0); #1;
        chk("full load ready", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0); dm_gnt = 1'b1; #1;
        chk("full ld dm_r", 32'(dm_r), 32'd1);
        chk("full ld dm_w", 32'(dm_w), 32'd0);
        chk("full ld addr", dm_addr, 32'h20);
        step(); #1;
        chk("full ld rsp_valid", 32'(rsp_valid), 32'd1);
        chk("full ld rsp_rdata", rsp_rdata, 32'h55);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) begin
                step(); #1;
            end
            chk("full drain dm_w", 32'(dm_w), 32'd1);
            chk("full drain addr", dm_addr, 32'h10 + 32'(k));
            chk("full drain data", dm_wdata, 32'hA0 + 32'(k));
            chk_strobes("full drain");
        end
        step(); #1;
        chk("full drained sb_empty", 32'(sb_empty), 32'd1);
        chk("full drained dm_w", 32'(dm_w), 32'd0);
        chk("full mem[0x13]", mem[16'h13], 32'hA3);

        // ---------------- grant stall ----------------
        step(); dm_gnt = 1'b0; drive(1'b1, 1'b0, 32'd2, 32'd0); #1;
        chk("stall ready", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            if (k != 0) step();
            #1;
            chk("stall dm_r low", 32'(dm_r), 32'd0);
            chk("stall rsp_valid low", 32'(rsp_valid), 32'd0);
        end
        step(); dm_gnt = 1'b1; #1;
        chk("stall granted dm_r", 32'(dm_r), 32'd1);
        chk("stall granted addr", dm_addr, 32'd2);
        step(); #1;
        chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
        chk("stall rsp_rdata", rsp_rdata, 32'd31);
        step(); #1;
        chk("stall rsp one cycle", 32'(rsp_valid), 32'd0);

        // ---------------- drain/accept collision ----------------
        dm_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(); drive(1'b1, 1'b1, 32'h30 + 32'(k), 32'hB0 + 32'(k)); #1;
            chk("coll push ready", 32'(req_ready), 32'd1);
        end
        step(); dm_gnt = 1'b1; drive(1'b1, 1'b1, 32'h34, 32'hB4); #1;
        chk("coll drain dm_w", 32'(dm_w), 32'd1);
        chk("coll drain addr", dm_addr, 32'h30);
        chk("coll ready blocked", 32'(req_ready), 32'd0);
        step(); dm_gnt = 1'b0; #1;
        chk("coll ready next", 32'(req_ready), 32'd1);
        step(); drive(1'b0, 1'b1, 32'h35, 32'hB5); #1;
        chk("coll full again", 32'(req_ready), 32'd0);
        step(); drive(1'b0, 1'b0, 32'd0, 32'd0); dm_gnt = 1'b1;
        for (int k = 1; k < 5; k++) begin
            if (k != 1) step();
            #1;
            chk("coll drain2 dm_w", 32'(dm_w), 32'd1);
            chk("coll drain2 addr", dm_addr, 32'h30 + 32'(k));
            chk("coll drain2 data", dm_wdata, 32'hB0 + 32'(k));
        end
        step(); #1;
        chk("coll sb_empty", 32'(sb_empty), 32'd1);
        chk("coll idle dm_addr", dm_addr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
